// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: opcodes, sequencer states, instruction field slices and the
// T-step at which the processor raises Done for each opcode.
`default_nettype none

package proc_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam int F_HI    = 13;
  localparam int F_LO    = 12;
  localparam int RX_HI   = 11;
  localparam int RX_LO   = 10;
  localparam int RY_HI   = 9;
  localparam int RY_LO   = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_ERROR = 3'd4
  } seq_state_t;

  function automatic logic [1:0] exp_phase(input logic [1:0] op);
    return (op == OP_ADD || op == OP_SUB) ? 2'd3 : 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_mirror.sv
// phase_mirror: shadow of the processor's T0-T3 step counter.
// Revision: 1.0
`default_nettype none

module phase_mirror
  import proc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       proc_rst,
  input  logic       w,
  input  logic       done,
  output logic [1:0] phase,
  output logic [1:0] phase_next
);

  logic [1:0] r_phase;
  logic [1:0] w_next;

  always_comb begin
    w_next = r_phase + 2'd1;
    if (proc_rst || done || (!w && r_phase == 2'd3)) w_next = 2'd0;
  end

  always_ff @(posedge clk) begin
    r_phase <= w_next;
  end

  assign phase      = r_phase;
  assign phase_next = w_next;

endmodule

`default_nettype wire

// File: rtl/proc_sequencer.sv
// proc_sequencer: issues program words to the 4-register bus processor over w/Done.
// Optional phase checking and ERROR state under macro PROC_SEQ_CHECK_EN. Revision: 1.0
`default_nettype none

module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [13:0]   prog_wdata,
  input  logic [AW-1:0] prog_last,
  output logic          proc_rst,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    data,
  input  logic          done,
  input  logic [7:0]    bus,
  output logic [7:0]    result,
  output logic          result_valid,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [AW-1:0] pc
);

  logic [13:0]   r_mem [2**AW];
  seq_state_t    r_state;
  logic          r_proc_rst, r_w, r_busy, r_finished, r_result_valid;
  logic [1:0]    r_F, r_Rx, r_Ry;
  logic [7:0]    r_data, r_result;
  logic [AW-1:0] r_pc, r_last;

  logic [1:0]    w_phase, w_phase_next;
  logic          w_mirror_clr, w_in_exec, w_retire, w_fault;
  logic [AW-1:0] w_fetch_addr;
  logic [13:0]   w_word;

  // The mirror clears on the reset edge itself, before proc_rst is registered.
  assign w_mirror_clr = r_proc_rst | ~reset;

  phase_mirror u_phase_mirror (
    .clk        (clk),
    .proc_rst   (w_mirror_clr),
    .w          (r_w),
    .done       (done),
    .phase      (w_phase),
    .phase_next (w_phase_next)
  );

  assign w_in_exec    = (r_state == S_EXEC);
  assign w_fetch_addr = w_in_exec ? (r_pc + AW'(1)) : r_pc;
  assign w_word       = r_mem[w_fetch_addr];

`ifdef PROC_SEQ_CHECK_EN
  logic w_at_exp;
  logic r_err;
  assign w_at_exp = (w_phase == exp_phase(r_F));
  assign w_retire = w_in_exec & done & w_at_exp;
  assign w_fault  = w_in_exec & (done ^ w_at_exp);
  always_ff @(posedge clk) begin
    if (!reset)       r_err <= 1'b0;
    else if (w_fault) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_phase_unused;
  assign w_phase_unused = ^w_phase;
  assign w_retire = w_in_exec & done;
  assign w_fault  = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) r_mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_proc_rst     <= 1'b1;
      r_w            <= 1'b0;
      r_F            <= 2'd0;
      r_Rx           <= 2'd0;
      r_Ry           <= 2'd0;
      r_data         <= 8'd0;
      r_result       <= 8'd0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_finished     <= 1'b0;
      r_pc           <= '0;
      r_last         <= '0;
    end else begin
      r_proc_rst     <= 1'b0;
      r_result_valid <= 1'b0;
      r_finished     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last  <= prog_last;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_phase_next == 2'd0) begin
            r_F     <= w_word[F_HI:F_LO];
            r_Rx    <= w_word[RX_HI:RX_LO];
            r_Ry    <= w_word[RY_HI:RY_LO];
            r_data  <= w_word[DATA_HI:DATA_LO];
            r_w     <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_w     <= 1'b0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_retire) begin
            r_result       <= bus;
            r_result_valid <= 1'b1;
            if (r_pc == r_last) begin
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              // Done returns the processor to T0 next cycle, so issue back-to-back.
              r_pc    <= w_fetch_addr;
              r_F     <= w_word[F_HI:F_LO];
              r_Rx    <= w_word[RX_HI:RX_LO];
              r_Ry    <= w_word[RY_HI:RY_LO];
              r_data  <= w_word[DATA_HI:DATA_LO];
              r_w     <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (w_fault) begin
            r_w     <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_ERROR;
          end
        end
        S_ERROR: begin
          r_w    <= 1'b0;
          r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign proc_rst     = r_proc_rst;
  assign w            = r_w;
  assign F            = r_F;
  assign Rx           = r_Rx;
  assign Ry           = r_Ry;
  assign data         = r_data;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign finished     = r_finished;
  assign pc           = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: drives proc_sequencer against a behavioural 4-register processor
// and checks results against a program-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_proc_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [13:0]   prog_wdata = '0;
  logic [AW-1:0] prog_last = '0;
  logic          proc_rst, w, done;
  logic [1:0]    F, Rx, Ry;
  logic [7:0]    data, bus, result;
  logic          result_valid, busy, finished, err;
  logic [AW-1:0] pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wcnt = 0;
  int first_w = -1;
  int start_cyc = 0;

  logic [13:0] prog_img [16];
  logic [7:0]  ref_R [4];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  proc_sequencer #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_last(prog_last),
    .proc_rst(proc_rst), .w(w), .F(F), .Rx(Rx), .Ry(Ry), .data(data),
    .done(done), .bus(bus), .result(result), .result_valid(result_valid),
    .busy(busy), .finished(finished), .err(err), .pc(pc)
  );

  // Behavioural processor: T-step counter, IR capture at T0, Done at T1 or T3.
  logic [1:0] T, iF, iX, iY;
  logic       act, late;
  logic [7:0] R [4];
  logic [7:0] A, G;
  bit         suppress = 1'b0;

  always_comb begin
    done = 1'b0;
    bus  = 8'h00;
    if (act) begin
      if (late) begin
        done = 1'b1;
        bus  = G;
      end else begin
        case (T)
          2'd1: begin
            if (!iF[1]) begin
              done = 1'b1;
              bus  = (iF == 2'd0) ? data : R[iY];
            end else begin
              bus = R[iX];
            end
          end
          2'd2: bus = R[iY];
          2'd3: begin
            bus  = G;
            done = !suppress;
          end
          default: bus = 8'h00;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (proc_rst) begin
      T <= 2'd0; act <= 1'b0; late <= 1'b0; A <= 8'd0; G <= 8'd0;
      for (int i = 0; i < 4; i++) R[i] <= 8'd0;
    end else begin
      T <= (done || (!w && T == 2'd3)) ? 2'd0 : T + 2'd1;
      if (!act && T == 2'd0 && w) begin
        act <= 1'b1; iF <= F; iX <= Rx; iY <= Ry;
      end else if (act) begin
        if (late) begin
          R[iX] <= G; act <= 1'b0; late <= 1'b0;
        end else begin
          case (T)
            2'd1: begin
              if (iF == 2'd0)      begin R[iX] <= data;  act <= 1'b0; end
              else if (iF == 2'd1) begin R[iX] <= R[iY]; act <= 1'b0; end
              else A <= R[iX];
            end
            2'd2: G <= iF[0] ? (A - R[iY]) : (A + R[iY]);
            2'd3: begin
              if (suppress) late <= 1'b1;
              else begin R[iX] <= G; act <= 1'b0; end
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) got_q.push_back(result);
    if (w === 1'b1) begin
      wcnt++;
      if (first_w < 0) first_w = cyc;
      check("w_on_T0", {30'd0, T}, 32'd0);
    end
  end

  function automatic logic [31:0] qget(input int i);
    return (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hxxxxxxxx;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_proc_rst"}, proc_rst, 1);
    check({tag, "_w"}, w, 0);
    check({tag, "_F"}, F, 0);
    check({tag, "_Rx"}, Rx, 0);
    check({tag, "_Ry"}, Ry, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rvalid"}, result_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pc"}, pc, 0);
  endtask

  task automatic write_prog(input int addr, input logic [13:0] word);
    prog_we    = 1'b1;
    prog_addr  = addr[AW-1:0];
    prog_wdata = word;
    prog_img[addr] = word;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Reference: execute the program image instruction by instruction.
  task automatic build_expect(input int last);
    exp_q.delete();
    for (int i = 0; i <= last; i++) begin
      logic [13:0] ins;
      int x, y;
      ins = prog_img[i];
      x = int'(ins[11:10]);
      y = int'(ins[9:8]);
      case (ins[13:12])
        2'd0: ref_R[x] = ins[7:0];
        2'd1: ref_R[x] = ref_R[y];
        2'd2: ref_R[x] = ref_R[x] + ref_R[y];
        default: ref_R[x] = ref_R[x] - ref_R[y];
      endcase
      exp_q.push_back(ref_R[x]);
    end
  endtask

  task automatic run_prog(input int last, input int want_phase, input bit interfere, input string tag);
    bit seen;
    build_expect(last);
    got_q.delete();
    wcnt = 0;
    first_w = -1;
    if (want_phase >= 0)
      for (int k = 0; k < 8 && T != 2'(want_phase); k++) begin @(posedge clk); #1; end
    start = 1'b1;
    prog_last = last[AW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (interfere && k == 2) begin
        prog_we = 1'b1; prog_addr = '0; prog_wdata = ~prog_img[0]; start = 1'b1;
      end
      @(posedge clk); #1;
      prog_we = 1'b0;
      start = 1'b0;
      if (finished === 1'b1) seen = 1'b1;
    end
    check({tag, "_finished"}, seen, 1);
    @(negedge clk); #1;
    check({tag, "_nres"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_res%0d", tag, i), qget(i), {24'd0, exp_q[i]});
    check({tag, "_wcnt"}, wcnt, last + 1);
    check({tag, "_lat"}, (first_w - start_cyc >= 1) && (first_w - start_cyc <= 4), 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    @(posedge clk); #1;
    check({tag, "_fin_pulse"}, finished, 0);
  endtask

  task automatic load_add_prog();
    write_prog(0, 14'h002A);
    write_prog(1, 14'h0455);
    write_prog(2, 14'h2400);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) ref_R[i] = 8'd0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_R[i] = 8'd0;
    for (int i = 0; i < 16; i++) prog_img[i] = 14'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_proc_rst", proc_rst, 0);
    for (int i = 0; i < 16; i++) write_prog(i, 14'd0);

    load_add_prog();
    run_prog(2, -1, 0, "add");
    check("add_r0", qget(0), 32'h2A);
    check("add_r1", qget(1), 32'h55);
    check("add_r2", qget(2), 32'h7F);
    check("add_procR1", {24'd0, R[1]}, 32'h7F);

    write_prog(2, 14'h3100);
    run_prog(2, -1, 0, "sub_wrap");
    check("sub_wrap_val", qget(2), 32'hD5);
    write_prog(2, 14'h3400);
    run_prog(2, -1, 0, "sub");
    check("sub_val", qget(2), 32'h2B);

    write_prog(0, {2'b00, 2'd2, 2'd0, 8'($urandom)});
    for (int p = 0; p < 4; p++) run_prog(0, p, 0, $sformatf("align%0d", p));

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 16; a++) write_prog(a, 14'($urandom));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      run_prog(int'($urandom_range(0, 15)), -1, 0, $sformatf("rand%0d", r));
    end

    for (int a = 0; a < 8; a++) write_prog(a, 14'($urandom));
    run_prog(7, -1, 1, "busy");
    run_prog(7, -1, 0, "rerun");

    load_add_prog();
    suppress = 1'b1;
`ifdef PROC_SEQ_CHECK_EN
    begin
      bit seen_err;
      seen_err = 1'b0;
      start = 1'b1; prog_last = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && !seen_err; k++) begin
        @(posedge clk); #1;
        if (err === 1'b1) seen_err = 1'b1;
      end
      check("err_set", err, 1);
      check("err_w", w, 0);
      check("err_busy", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("err_start_busy", busy, 0);
      check("err_start_w", w, 0);
      check("err_sticky", err, 1);
      suppress = 1'b0;
      reset_pulse();
      check("err_cleared", err, 0);
    end
`else
    run_prog(2, -1, 0, "late");
    check("late_val", qget(2), 32'h7F);
    suppress = 1'b0;
`endif

    load_add_prog();
    wcnt = 0;
    start = 1'b1; prog_last = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && wcnt < 3; k++) begin @(posedge clk); #1; end
    check("midrst_reached_add", wcnt, 3);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_release", proc_rst, 0);
    for (int i = 0; i < 4; i++) ref_R[i] = 8'd0;
    run_prog(2, -1, 0, "after_rst");
    check("after_rst_val", qget(2), 32'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_sequencer.md
# proc_sequencer

- Instruction-issuing front end for the 4-register bus processor.
- Holds a small program memory of `{F, Rx, Ry, data}` words and issues them one at a time over the processor's `w`/`Done` handshake.
- Mirrors the processor's T0–T3 step counter, so `w` always lands exactly on T0.
- Samples `BusWires` at retirement to return each instruction's result, and flags handshake violations.

## Interface
- `AW`, 4: program address width; depth is 2**AW words.
- `clk`  in  1  rising-edge clock, shared with the processor.
- `reset`  in  1  synchronous, active-low; 0 resets the block.
- `start`  in  1  pulse; begins execution at pc 0; honoured in IDLE only.
- `prog_we`  in  1  program write strobe; ignored while `busy`.
- `prog_addr`  in  AW  program write address.
- `prog_wdata`  in  14  instruction word: `[13:12]` F, `[11:10]` Rx, `[9:8]` Ry, `[7:0]` data.
- `prog_last`  in  AW  index of the last instruction; sampled on accepted `start`.
- `proc_rst`  out  1  active-high reset to the processor.
- `w`  out  1  instruction-valid to the processor.
- `F`, `Rx`, `Ry`  out  2 each  instruction fields.
- `data`  out  8  external operand.
- `done`  in  1  processor `Done`.
- `bus`  in  8  processor `BusWires`.
- `result`  out  8  bus value captured at retirement.
- `result_valid`  out  1  one-cycle pulse.
- `busy`  out  1  high from accepted `start` until `finished` or error.
- `finished`  out  1  one-cycle pulse after the last retirement.
- `err`  out  1  sticky protocol error.
- `pc`  out  AW  index of the current instruction.

## Operation
Opcodes:
- `00` LOAD: external data into Rx.
- `01` MOVE: Ry into Rx.
- `10` ADD: Rx += Ry.
- `11` SUB: Rx -= Ry.

Expected `done` phase:
- 1 for `00`/`01`.
- 3 for `10`/`11`.

Phase mirror:
- 2-bit `phase` register.
- Next value is 0 if `proc_rst | done | (~w & phase==3)`, otherwise `phase+1` (wraps 3→0).

FSM states IDLE, ALIGN, ISSUE, EXEC, ERROR:
- IDLE: `start` latches `prog_last`, sets pc=0 and `busy`=1, then goes to ALIGN.
- ALIGN: when next phase==0, register the fields of `mem[pc]`, set `w`=1, then go to ISSUE.
- ISSUE: one cycle with `phase==0` and `w==1`, in which the processor captures the instruction. At the edge, `w`=0 and the state goes to EXEC.
- EXEC, `phase` == expected and `done`=1: the instruction retires.
  - `result`<=`bus` and `result_valid` pulses next cycle.
  - If pc==`prog_last`: IDLE, `busy`=0, `finished` pulses.
  - Otherwise pc+1, load the next fields, `w`=1, go to ISSUE. The next cycle is T0, so there is no bubble.
- EXEC, `done`=1 before the expected phase, or `done`=0 at the expected phase: go to ERROR.
- ERROR: `err`=1, `w`=0, `busy`=0. Held until reset.

Other rules:
- `F`/`Rx`/`Ry`/`data` stay stable from ISSUE through retirement, because `data` is consumed at T1.
- Outside ISSUE they hold their last value.
- `done` is ignored in IDLE and ALIGN (stale `Done` pulses from the previous instruction are expected there).
- Arithmetic is the processor's; `result` is the 8-bit wrapped value.

## Timing
Reset values:
- `proc_rst`=1.
- 0: `w`, `F`, `Rx`, `Ry`, `data`, `result`, `result_valid`, `busy`, `finished`, `err`, `pc`, `phase`.
- State IDLE.
- Program memory is not reset.

Latencies:
- `proc_rst` falls one edge after `reset` rises; `phase` stays 0 while `proc_rst`=1.
- `start` to first `w`: 1–4 cycles (alignment).
- LOAD/MOVE: 2 cycles, ISSUE to retire.
- ADD/SUB: 4 cycles, ISSUE to retire.
- `result_valid`: 1 cycle after retire.

Boundary cases:
- `reset` low mid-instruction: all state returns to reset values at that edge and `proc_rst` is asserted.
- `start` and `prog_we` together in IDLE: the write occurs and execution starts. The write is visible if the address is not read in ALIGN that same cycle.
- `start` while `busy` or in ERROR: ignored.

## Configuration
`PROC_SEQ_CHECK_EN`:
- Defined: the EXEC checks above are active, and the ERROR state and `err` exist.
- Undefined: EXEC retires on the first `done` with no phase checks, `err` is tied 0, and ERROR is unreachable.

## Structure
`proc_seq_pkg` holds:
- Opcode constants `OP_LOAD`/`OP_MOVE`/`OP_ADD`/`OP_SUB`.
- The state enum.
- Instruction field slice constants.
- The `exp_phase(op)` function.

Sub-module `phase_mirror`:
- Inputs: `clk`, `proc_rst`, `w`, `done`.
- Outputs: `phase`, `phase_next`.

## Test plan
- Load program LOAD R0 0x2A; LOAD R1 0x55; ADD R1,R0 with `prog_last`=2, then `start` -> three `w` pulses, each at phase 0; `result` values 0x2A, 0x55, 0x7F; `finished` pulses; processor R1=0x7F.
- After the same loads, SUB R0,R1 -> `result`=0xD5 (wrap); SUB R1,R0 in a fresh run -> 0x2B.
- `start` asserted at each idle phase 0..3 -> first `w` within 4 cycles, always coincident with phase 0.
- Fake responder holds `done`=0 at phase 3 of an ADD, with the macro defined -> `err`=1, `w`=0, `busy`=0, `start` ignored; without the macro -> retires on the late `done`.
- `reset`=0 during EXEC of an ADD -> next cycle all outputs at reset values and `proc_rst`=1; a re-run gives correct results.
- `prog_we` and `start` pulses while `busy` -> no effect; a rerun reproduces the original results.
